// File: rtl/regfile_2w2r_sb.sv
// Two-write/two-read register file with per-register busy scoreboard; REGFILE_BYPASS_EN adds write-through reads.
// Latency: reads and busy flags are combinational, writes/busy/busy_cnt update at the rising edge.
// Backpressure: none; decode is expected to stall on busy before reissuing a destination.
module regfile_2w2r_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_write0,
    input  logic [ADDR_W-1:0] write_add0,
    input  logic [DATA_W-1:0] write_data0,
    input  logic              en_write1,
    input  logic [ADDR_W-1:0] write_add1,
    input  logic [DATA_W-1:0] write_data1,
    input  logic [ADDR_W-1:0] read_add1,
    input  logic [ADDR_W-1:0] read_add2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_add,
    output logic              busy1,
    output logic              busy2,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0] mem [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic [ADDR_W:0]   busy_cnt_q;
    logic [ADDR_W:0]   cnt_d;

    logic [ADDR_W-1:0] radd  [2];
    logic [DATA_W-1:0] rdat  [2];
    logic [1:0]        rbusy;

    logic wr0_ok;
    logic wr1_ok;

    assign wr0_ok = en_write0 && !(ZERO_REG != 0 && write_add0 == '0);
    assign wr1_ok = en_write1 && !(ZERO_REG != 0 && write_add1 == '0);

    // Port 1 is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr0_ok) mem[write_add0] <= write_data0;
            if (wr1_ok) mem[write_add1] <= write_data1;
        end
    end

    // Issue is applied after the clears: a newer producer is in flight.
    always_comb begin
        busy_d = busy_q;
        if (en_write0) busy_d[write_add0] = 1'b0;
        if (en_write1) busy_d[write_add1] = 1'b0;
        if (issue_en)  busy_d[issue_add]  = 1'b1;
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_d = cnt_d + (ADDR_W+1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= cnt_d;
        end
    end

    assign radd[0] = read_add1;
    assign radd[1] = read_add2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdat[p]  = mem[radd[p]];
            rbusy[p] = busy_q[radd[p]];
`ifdef REGFILE_BYPASS_EN
            if (en_write0 && write_add0 == radd[p]) begin
                rdat[p]  = write_data0;
                rbusy[p] = issue_en && (issue_add == radd[p]);
            end
            if (en_write1 && write_add1 == radd[p]) begin
                rdat[p]  = write_data1;
                rbusy[p] = issue_en && (issue_add == radd[p]);
            end
`endif
            if (ZERO_REG != 0 && radd[p] == '0) begin
                rdat[p]  = '0;
                rbusy[p] = 1'b0;
            end
        end
    end

    assign read_data1 = rdat[0];
    assign read_data2 = rdat[1];
    assign busy1      = rbusy[0];
    assign busy2      = rbusy[1];
    assign busy_cnt   = busy_cnt_q;

endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Bench for regfile_2w2r_sb: directed vector table, bypass/zero-register sequences, random phase against a model.
module tb_regfile_2w2r_sb;

    logic        clk;
    logic        rst;
    logic        en_write0;
    logic [4:0]  write_add0;
    logic [31:0] write_data0;
    logic        en_write1;
    logic [4:0]  write_add1;
    logic [31:0] write_data1;
    logic [4:0]  read_add1;
    logic [4:0]  read_add2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        issue_en;
    logic [4:0]  issue_add;
    logic        busy1;
    logic        busy2;
    logic [5:0]  busy_cnt;

    regfile_2w2r_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .en_write0(en_write0), .write_add0(write_add0), .write_data0(write_data0),
        .en_write1(en_write1), .write_add1(write_add1), .write_data1(write_data1),
        .read_add1(read_add1), .read_add2(read_add2),
        .read_data1(read_data1), .read_data2(read_data2),
        .issue_en(issue_en), .issue_add(issue_add),
        .busy1(busy1), .busy2(busy2), .busy_cnt(busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ew0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        ew1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        ie;
        logic [4:0]  ia;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        b1;
        logic        b2;
        logic [5:0]  cnt;
    } vec_t;

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        b1;
        logic        b2;
        logic [5:0]  cnt;
    } exp_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb [$];
    vec_t tbl [19];

    logic [31:0] m_mem  [32];
    logic        m_busy [32];

    function automatic vec_t mk(logic r, logic e0, logic [4:0] a0, logic [31:0] d0,
                                logic e1, logic [4:0] a1, logic [31:0] d1,
                                logic ie, logic [4:0] ia, logic [4:0] r1, logic [4:0] r2,
                                logic [31:0] x1, logic [31:0] x2, logic y1, logic y2, logic [5:0] c);
        vec_t v;
        v.rst = r;  v.ew0 = e0; v.wa0 = a0; v.wd0 = d0;
        v.ew1 = e1; v.wa1 = a1; v.wd1 = d1; v.ie = ie; v.ia = ia;
        v.ra1 = r1; v.ra2 = r2; v.rd1 = x1; v.rd2 = x2; v.b1 = y1; v.b2 = y2; v.cnt = c;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e);
        chk({tag, "_rd1"}, read_data1, e.rd1);
        chk({tag, "_rd2"}, read_data2, e.rd2);
        chk({tag, "_b1"}, 32'(busy1), 32'(e.b1));
        chk({tag, "_b2"}, 32'(busy2), 32'(e.b2));
        chk({tag, "_cnt"}, 32'(busy_cnt), 32'(e.cnt));
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst;
        en_write0 = v.ew0; write_add0 = v.wa0; write_data0 = v.wd0;
        en_write1 = v.ew1; write_add1 = v.wa1; write_data1 = v.wd1;
        issue_en = v.ie; issue_add = v.ia;
        read_add1 = v.ra1; read_add2 = v.ra2;
    endtask

    task automatic quiet();
        rst = 1'b0; en_write0 = 1'b0; en_write1 = 1'b0; issue_en = 1'b0;
    endtask

    // Drive one cycle, queue its expectation, then compare after the edge with controls dropped.
    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        exp_t got;
        @(negedge clk);
        apply(v);
        e.rd1 = v.rd1; e.rd2 = v.rd2; e.b1 = v.b1; e.b2 = v.b2; e.cnt = v.cnt;
        sb.push_back(e);
        @(posedge clk);
        #1 quiet();
        #1;
        if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL %s_queue: got empty expected entry", tag);
        end else begin
            got = sb.pop_front();
            cmp(tag, got);
        end
    endtask

    // Reference model step: fills the expectation fields of v from the model state.
    task automatic model_step(inout vec_t v);
        int c;
        if (v.rst) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i] = 32'd0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (v.ew0 && v.wa0 != 5'd0) m_mem[v.wa0] = v.wd0;
            if (v.ew1 && v.wa1 != 5'd0) m_mem[v.wa1] = v.wd1;
            if (v.ew0) m_busy[v.wa0] = 1'b0;
            if (v.ew1) m_busy[v.wa1] = 1'b0;
            if (v.ie && v.ia != 5'd0) m_busy[v.ia] = 1'b1;
        end
        c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        v.rd1 = (v.ra1 == 5'd0) ? 32'd0 : m_mem[v.ra1];
        v.rd2 = (v.ra2 == 5'd0) ? 32'd0 : m_mem[v.ra2];
        v.b1  = m_busy[v.ra1];
        v.b2  = m_busy[v.ra2];
        v.cnt = 6'(c);
    endtask

    function automatic logic [4:0] rnd_addr();
        return ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] x_rd;
        logic        x_b;
        vec_t        v;

        quiet();
        write_add0 = '0; write_data0 = '0; write_add1 = '0; write_data1 = '0;
        issue_add = '0; read_add1 = '0; read_add2 = '0;

        //              rst ew0 wa0 wd0           ew1 wa1 wd1   ie ia  ra1 ra2  rd1 rd2  b1 b2 cnt
        tbl[0]  = mk(1, 0, 0,  0,            0, 0,  0,   0, 0,  3,  31, 0,   0,   0, 0, 0);
        tbl[1]  = mk(0, 1, 10, 101,          1, 11, 200, 0, 0,  10, 11, 101, 200, 0, 0, 0);
        tbl[2]  = mk(0, 1, 12, 5,            1, 12, 7,   0, 0,  12, 10, 7,   101, 0, 0, 0);
        tbl[3]  = mk(0, 1, 0,  32'hDEADBEEF, 0, 0,  0,   1, 0,  0,  11, 0,   200, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0,  0,            0, 0,  0,   1, 5,  5,  6,  0,   0,   1, 0, 1);
        tbl[5]  = mk(0, 0, 0,  0,            0, 0,  0,   1, 6,  5,  6,  0,   0,   1, 1, 2);
        tbl[6]  = mk(0, 1, 5,  55,           0, 0,  0,   1, 6,  5,  6,  55,  0,   0, 1, 1);
        tbl[7]  = mk(0, 0, 0,  0,            1, 6,  66,  1, 6,  5,  6,  55,  66,  0, 1, 1);
        tbl[8]  = mk(0, 1, 20, 3,            0, 0,  0,   0, 0,  20, 6,  3,   66,  0, 1, 1);
        tbl[9]  = mk(0, 0, 0,  0,            1, 6,  67,  0, 0,  6,  5,  67,  55,  0, 0, 0);
        tbl[10] = mk(0, 0, 0,  0,            0, 0,  0,   1, 7,  7,  8,  0,   0,   1, 0, 1);
        tbl[11] = mk(0, 0, 0,  0,            0, 0,  0,   1, 8,  7,  8,  0,   0,   1, 1, 2);
        tbl[12] = mk(0, 1, 7,  1,            1, 8,  2,   0, 0,  7,  8,  1,   2,   0, 0, 0);
        tbl[13] = mk(0, 0, 0,  0,            0, 0,  0,   1, 1,  1,  4,  0,   0,   1, 0, 1);
        tbl[14] = mk(0, 0, 0,  0,            0, 0,  0,   1, 2,  1,  4,  0,   0,   1, 0, 2);
        tbl[15] = mk(0, 0, 0,  0,            0, 0,  0,   1, 4,  1,  4,  0,   0,   1, 1, 3);
        tbl[16] = mk(1, 0, 0,  0,            1, 4,  77,  1, 3,  4,  10, 0,   0,   0, 0, 0);
        tbl[17] = mk(0, 1, 9,  1,            0, 0,  0,   1, 9,  9,  12, 1,   0,   1, 0, 1);
        tbl[18] = mk(0, 0, 0,  0,            0, 0,  0,   0, 0,  9,  31, 1,   0,   1, 0, 1);

        for (int i = 0; i < 19; i++) begin
            run_vec(tbl[i], $sformatf("v%0d", i));
        end

        // Same-cycle write to busy reg 9: bypass returns write data and clears busy unless reissued.
        @(negedge clk);
        en_write0 = 1'b1; write_add0 = 5'd9; write_data0 = 32'd42; read_add1 = 5'd9;
        #1;
`ifdef REGFILE_BYPASS_EN
        x_rd = 32'd42; x_b = 1'b0;
`else
        x_rd = 32'd1;  x_b = 1'b1;
`endif
        chk("byp_p0_rd1", read_data1, x_rd);
        chk("byp_p0_b1", 32'(busy1), 32'(x_b));
        en_write1 = 1'b1; write_add1 = 5'd9; write_data1 = 32'd43;
        #1;
`ifdef REGFILE_BYPASS_EN
        x_rd = 32'd43;
`else
        x_rd = 32'd1;
`endif
        chk("byp_p1_rd1", read_data1, x_rd);
        issue_en = 1'b1; issue_add = 5'd9;
        #1;
        chk("byp_issue_b1", 32'(busy1), 32'd1);
        read_add2 = 5'd0; write_add0 = 5'd0;
        #1;
        chk("byp_zero_rd2", read_data2, 32'd0);
        write_add0 = 5'd9;
        @(posedge clk);
        #1 quiet();
        #1;
        chk("byp_post_rd1", read_data1, 32'd43);
        chk("byp_post_b1", 32'(busy1), 32'd1);
        chk("byp_post_cnt", 32'(busy_cnt), 32'd1);

        // Random phase against the model, starting from a reset.
        v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_step(v);
        run_vec(v, "rnd_rst");
        for (int n = 0; n < 300; n++) begin
            v.rst = ($urandom_range(0, 59) == 0);
            v.ew0 = 1'($urandom_range(0, 1));
            v.wa0 = rnd_addr();
            v.wd0 = $urandom;
            v.ew1 = 1'($urandom_range(0, 1));
            v.wa1 = ($urandom_range(0, 3) == 0) ? v.wa0 : rnd_addr();
            v.wd1 = $urandom;
            v.ie  = 1'($urandom_range(0, 1));
            v.ia  = rnd_addr();
            v.ra1 = rnd_addr();
            v.ra2 = rnd_addr();
            model_step(v);
            run_vec(v, $sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
